alu_req_arbiter: RTL and testbench

ALU_REQ_ARBITER -- requirements
Module: alu_req_arbiter

---
 rtl/alu_req_arbiter_if.sv | 40 ++++
 rtl/alu_req_arbiter.sv | 106 ++++++++++
 tb/tb_alu_req_arbiter.sv | 330 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_req_arbiter_if.sv
// Bundle of request, ALU and response signals shared between the requester
// side (master) and the arbiter (slave) that fronts a single ALU.
interface alu_req_arbiter_if #(
    parameter int WIDTH = 32,
    parameter int NREQ  = 4
) ();
    localparam int ID_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [NREQ-1:0]           req_valid;
    logic [NREQ-1:0]           req_ready;
    logic [NREQ*(WIDTH+1)-1:0] req_rs1;
    logic [NREQ*(WIDTH+1)-1:0] req_rs2;
    logic [NREQ*3-1:0]         req_funct3;
    logic [NREQ-1:0]           req_funct7;

    logic [WIDTH:0]            alu_rs1;
    logic [WIDTH:0]            alu_rs2;
    logic [2:0]                alu_funct3;
    logic                      alu_funct7;
    logic [WIDTH:0]            alu_rd;

    logic                      rsp_valid;
    logic                      rsp_ready;
    logic [ID_W-1:0]           rsp_id;
    logic [WIDTH:0]            rsp_data;

    modport slave (
        input  req_valid, req_rs1, req_rs2, req_funct3, req_funct7,
        input  alu_rd, rsp_ready,
        output req_ready, alu_rs1, alu_rs2, alu_funct3, alu_funct7,
        output rsp_valid, rsp_id, rsp_data
    );

    modport master (
        output req_valid, req_rs1, req_rs2, req_funct3, req_funct7,
        output alu_rd, rsp_ready,
        input  req_ready, alu_rs1, alu_rs2, alu_funct3, alu_funct7,
        input  rsp_valid, rsp_id, rsp_data
    );
endinterface

// File: rtl/alu_req_arbiter.sv
// Round-robin arbiter sharing one registered ALU among NREQ requesters:
// one operation in flight, IDLE -> EXEC -> CAPT -> RESP.
module alu_req_arbiter #(
    parameter int WIDTH = 32,
    parameter int NREQ  = 4
) (
    input  logic             clk,
    input  logic             rst,
    alu_req_arbiter_if.slave bus
);
    localparam int ID_W = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int DW   = WIDTH + 1;

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        CAPT,
        RESP
    } state_t;

    state_t          state;
    logic [ID_W-1:0] ptr;
    logic [ID_W-1:0] cur_id;
    logic [ID_W-1:0] grant_idx;
    logic            grant_found;
    int              idx;

    // Scan from the highest offset down so the nearest valid requester at or
    // after ptr is the last one written and therefore wins.
    always_comb begin
        // NOTE: every variable gets a default before the loop; without it a
        // cycle with no valid requester would leave grant_idx latched.
        grant_found = 1'b0;
        grant_idx   = '0;
        idx         = 0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            idx = int'(ptr) + k;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            if (bus.req_valid[idx]) begin
                grant_found = 1'b1;
                grant_idx   = ID_W'(idx);
            end
        end
    end

    // Ready is gated by reset so it is low while reset is held, even in IDLE.
    always_comb begin
        bus.req_ready = '0;
        if (rst && (state == IDLE) && grant_found) begin
            bus.req_ready[grant_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            // NOTE: the datapath registers are reset as well as the control
            // state, since their reset values are visible on the ports.
            state          <= IDLE;
            ptr            <= '0;
            cur_id         <= '0;
            bus.alu_rs1    <= '0;
            bus.alu_rs2    <= '0;
            bus.alu_funct3 <= '0;
            bus.alu_funct7 <= 1'b0;
            bus.rsp_valid  <= 1'b0;
            bus.rsp_id     <= '0;
            bus.rsp_data   <= '0;
        end else begin
            // NOTE: non-blocking assignments throughout, so every register
            // sees the pre-edge value of every other register.
            case (state)
                IDLE: begin
                    if (grant_found) begin
                        bus.alu_rs1    <= bus.req_rs1[grant_idx*DW +: DW];
                        bus.alu_rs2    <= bus.req_rs2[grant_idx*DW +: DW];
                        bus.alu_funct3 <= bus.req_funct3[grant_idx*3 +: 3];
                        bus.alu_funct7 <= bus.req_funct7[grant_idx];
                        cur_id         <= grant_idx;
                        state          <= EXEC;
                    end
                end
                EXEC: begin
                    state <= CAPT;
                end
                CAPT: begin
                    bus.rsp_data  <= bus.alu_rd;
                    bus.rsp_id    <= cur_id;
                    bus.rsp_valid <= 1'b1;
                    state         <= RESP;
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        bus.rsp_valid <= 1'b0;
                        ptr           <= (cur_id == ID_W'(NREQ - 1)) ? '0 : cur_id + 1'b1;
                        state         <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_alu_req_arbiter.sv
// Self-checking bench: requester agents and an ALU stub around the arbiter,
// compared every cycle against a transaction-level reference model.
module tb_alu_req_arbiter;
    localparam int WIDTH = 32;
    localparam int NREQ  = 4;
    localparam int DW    = WIDTH + 1;

    typedef struct packed {
        logic [DW-1:0] rs1;
        logic [DW-1:0] rs2;
        logic [2:0]    f3;
        logic          f7;
    } op_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    alu_req_arbiter_if #(.WIDTH(WIDTH), .NREQ(NREQ)) bus ();
    alu_req_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ)) dut (.clk(clk), .rst(rst), .bus(bus));

    // Requester agents and response consumer.
    op_t req_op [NREQ];
    bit  pend   [NREQ];
    bit  refill;
    bit  rsp_rdy;

    // Reference model: one transaction in flight, aged in clock edges.
    bit  m_busy;
    int  m_age;
    int  m_ptr;
    int  m_cur;
    op_t m_alu;

    int n_vec = 0;
    int n_mis = 0;
    int cyc   = 0;
    bit prev_valid;
    int            obs_id   [$];
    logic [DW-1:0] obs_data [$];
    int            obs_rise [$];
    int            obs_acc  [$];

    function automatic logic [DW-1:0] alu_fn(input op_t o);
        logic [DW-1:0] r;
        case (o.f3)
            3'd0:    r = o.f7 ? o.rs1 - o.rs2 : o.rs1 + o.rs2;
            3'd1:    r = o.rs1 << o.rs2[4:0];
            3'd2:    r = {{(DW-1){1'b0}}, $signed(o.rs1) < $signed(o.rs2)};
            3'd3:    r = {{(DW-1){1'b0}}, o.rs1 < o.rs2};
            3'd4:    r = o.rs1 ^ o.rs2;
            3'd5:    r = o.f7 ? DW'($signed(o.rs1) >>> o.rs2[4:0]) : o.rs1 >> o.rs2[4:0];
            3'd6:    r = o.rs1 | o.rs2;
            default: r = o.rs1 & o.rs2;
        endcase
        return r;
    endfunction

    // Registered ALU: samples the operands every edge, result one clock later.
    always @(posedge clk) begin : alu_stub
        op_t a;
        a.rs1 = bus.alu_rs1;
        a.rs2 = bus.alu_rs2;
        a.f3  = bus.alu_funct3;
        a.f7  = bus.alu_funct7;
        bus.alu_rd <= alu_fn(a);
    end

    function automatic op_t rand_op();
        op_t o;
        o.rs1 = DW'({$urandom, $urandom});
        o.rs2 = DW'({$urandom, $urandom});
        o.f3  = 3'($urandom);
        o.f7  = 1'($urandom);
        return o;
    endfunction

    function automatic op_t mk_op(input int a, input int b, input int f3);
        op_t o;
        o.rs1 = DW'(a);
        o.rs2 = DW'(b);
        o.f3  = 3'(f3);
        o.f7  = 1'b0;
        return o;
    endfunction

    function automatic int model_grant();
        for (int k = 0; k < NREQ; k++) begin
            if (pend[(m_ptr + k) % NREQ]) return (m_ptr + k) % NREQ;
        end
        return -1;
    endfunction

    function automatic bit any_pend();
        for (int i = 0; i < NREQ; i++) if (pend[i]) return 1'b1;
        return 1'b0;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive();
        for (int i = 0; i < NREQ; i++) begin
            bus.req_valid[i]          = pend[i];
            bus.req_rs1[i*DW +: DW]   = req_op[i].rs1;
            bus.req_rs2[i*DW +: DW]   = req_op[i].rs2;
            bus.req_funct3[i*3 +: 3]  = req_op[i].f3;
            bus.req_funct7[i]         = req_op[i].f7;
        end
        bus.rsp_ready = rsp_rdy;
    endtask

    task automatic clear_obs();
        obs_id.delete();
        obs_data.delete();
        obs_rise.delete();
        obs_acc.delete();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req_ready"}, bus.req_ready, 0);
        check({tag, "_rsp_valid"}, bus.rsp_valid, 0);
        check({tag, "_rsp_id"}, bus.rsp_id, 0);
        check({tag, "_rsp_data"}, bus.rsp_data, 0);
        check({tag, "_alu_rs1"}, bus.alu_rs1, 0);
        check({tag, "_alu_rs2"}, bus.alu_rs2, 0);
        check({tag, "_alu_funct3"}, bus.alu_funct3, 0);
        check({tag, "_alu_funct7"}, bus.alu_funct7, 0);
    endtask

    // Asserts reset away from the clock edge, checks outputs at once and
    // again across an edge, then releases one time unit after an edge.
    task automatic reset_dut(input string tag);
        rst = 1'b0;
        drive();
        #1;
        m_busy = 1'b0;
        m_age  = 0;
        m_ptr  = 0;
        m_cur  = 0;
        m_alu  = '0;
        check_reset_outputs(tag);
        @(posedge clk);
        #1;
        check_reset_outputs({tag, "_held"});
        rst        = 1'b1;
        prev_valid = 1'b0;
        clear_obs();
    endtask

    // One clock: drive, compare against the model mid-cycle, then advance.
    task automatic tick();
        int               g;
        bit               exp_rv;
        bit               done;
        logic [NREQ-1:0]  exp_ready;
        drive();
        #2;
        g         = m_busy ? -1 : model_grant();
        exp_ready = (g >= 0) ? (NREQ'(1) << g) : '0;
        exp_rv    = m_busy && (m_age >= 2);
        check("req_ready", bus.req_ready, exp_ready);
        check("rsp_valid", bus.rsp_valid, exp_rv);
        if (exp_rv) begin
            check("rsp_id", bus.rsp_id, 64'(m_cur));
            check("rsp_data", bus.rsp_data, alu_fn(m_alu));
        end
        check("alu_rs1", bus.alu_rs1, m_alu.rs1);
        check("alu_rs2", bus.alu_rs2, m_alu.rs2);
        check("alu_funct3", bus.alu_funct3, m_alu.f3);
        check("alu_funct7", bus.alu_funct7, m_alu.f7);

        if (bus.rsp_valid && !prev_valid) obs_rise.push_back(cyc);
        prev_valid = bus.rsp_valid;
        if (bus.rsp_valid && bus.rsp_ready) begin
            obs_id.push_back(int'(bus.rsp_id));
            obs_data.push_back(bus.rsp_data);
        end
        if (|(bus.req_valid & bus.req_ready)) obs_acc.push_back(cyc);
        done = exp_rv && rsp_rdy;

        @(posedge clk);
        #1;
        cyc++;
        if (m_busy) m_age++;
        if (done) begin
            m_busy = 1'b0;
            m_ptr  = (m_cur + 1) % NREQ;
        end
        if (g >= 0) begin
            m_busy = 1'b1;
            m_age  = 0;
            m_cur  = g;
            m_alu  = req_op[g];
            if (refill) req_op[g] = rand_op();
            else        pend[g]   = 1'b0;
        end
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while ((m_busy || any_pend()) && n < budget) begin
            tick();
            n++;
        end
        check("drain_done", {m_busy, any_pend()}, 0);
    endtask

    initial begin
        int exp_order [5] = '{0, 1, 2, 3, 0};
        refill  = 1'b0;
        rsp_rdy = 1'b1;
        for (int i = 0; i < NREQ; i++) begin
            req_op[i] = rand_op();
            pend[i]   = 1'b1;
        end

        // Reset with every requester valid: ready must stay low.
        reset_dut("reset");
        for (int i = 0; i < NREQ; i++) pend[i] = 1'b0;

        // Single request on requester 0: 3 + 5.
        req_op[0] = mk_op(3, 5, 0);
        pend[0]   = 1'b1;
        drain(20);
        check("single_count", obs_id.size(), 1);
        if (obs_id.size() == 1 && obs_rise.size() == 1 && obs_acc.size() == 1) begin
            check("single_id", obs_id[0], 0);
            check("single_data", obs_data[0], 8);
            check("single_latency", obs_rise[0] - obs_acc[0], 3);
        end

        // All four continuously valid: strict rotation, 4 cycles apart.
        reset_dut("reset_rr");
        refill = 1'b1;
        for (int i = 0; i < NREQ; i++) begin
            req_op[i] = rand_op();
            pend[i]   = 1'b1;
        end
        repeat (21) tick();
        refill = 1'b0;
        drain(40);
        check("rr_count_ok", obs_id.size() >= 5, 1);
        if (obs_id.size() >= 5 && obs_rise.size() >= 5) begin
            for (int k = 0; k < 5; k++) check($sformatf("rr_id%0d", k), obs_id[k], exp_order[k]);
            for (int k = 1; k < 5; k++) check($sformatf("rr_gap%0d", k), obs_rise[k] - obs_rise[k-1], 4);
        end

        // Backpressure in RESP with another requester waiting.
        reset_dut("reset_bp");
        req_op[2] = rand_op();
        pend[2]   = 1'b1;
        rsp_rdy   = 1'b0;
        tick();
        req_op[1] = rand_op();
        pend[1]   = 1'b1;
        repeat (8) tick();
        rsp_rdy = 1'b1;
        drain(20);
        check("bp_count", obs_id.size(), 2);
        if (obs_id.size() == 2) begin
            check("bp_first", obs_id[0], 2);
            check("bp_second", obs_id[1], 1);
        end

        // Wrap: finish requester 2 so the pointer sits at 3, then 1 and 3.
        reset_dut("reset_wrap");
        req_op[2] = rand_op();
        pend[2]   = 1'b1;
        drain(20);
        req_op[1] = rand_op();
        req_op[3] = rand_op();
        pend[1]   = 1'b1;
        pend[3]   = 1'b1;
        drain(20);
        check("wrap_count", obs_id.size(), 3);
        if (obs_id.size() == 3) begin
            check("wrap_a", obs_id[1], 3);
            check("wrap_b", obs_id[2], 1);
        end

        // XOR and SLL through different requesters.
        clear_obs();
        req_op[1] = mk_op(32'hF0, 32'h0F, 4);
        pend[1]   = 1'b1;
        drain(20);
        req_op[2] = mk_op(2, 1, 1);
        pend[2]   = 1'b1;
        drain(20);
        check("ops_count", obs_data.size(), 2);
        if (obs_data.size() == 2) begin
            check("op_xor", obs_data[0], 'hFF);
            check("op_sll", obs_data[1], 4);
        end

        // Reset while the operation is in EXEC: no response afterwards.
        req_op[0] = rand_op();
        pend[0]   = 1'b1;
        tick();
        reset_dut("reset_mid");
        repeat (6) tick();
        check("mid_no_rsp", obs_rise.size(), 0);

        // Random traffic: arrivals, withdrawals before grant, backpressure.
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!pend[i] && $urandom_range(3) == 0) begin
                    req_op[i] = rand_op();
                    pend[i]   = 1'b1;
                end else if (pend[i] && $urandom_range(7) == 0) begin
                    pend[i] = 1'b0;
                end
            end
            rsp_rdy = ($urandom_range(2) != 0);
            refill  = ($urandom_range(1) != 0);
            tick();
        end
        refill  = 1'b0;
        rsp_rdy = 1'b1;
        drain(60);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end
endmodule
